uart_rx_ctrl: RTL

//  Receive-side frame sequencer for the serial `signal` line: detects start, times mid-bit samples,

---
 rtl/uart_rx_ctrl_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_bit_timer.sv | 27 ++
 rtl/uart_rx_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the serial receive sequencer: FSM states, line levels
// and bit-timing helpers.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // Cycles from start detection to the mid-start-bit recheck.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_bit_timer.sv
// Loadable down-counter for bit timing; tick marks a sample cycle and the
// count parks at zero until the next load.
module uart_rx_ctrl_bit_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side frame sequencer: start detect, mid-bit sampling, LSB-first
// shift, even parity and stop check, one-entry valid/ready output buffer.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (line high) while enabled
// ST_START  | waiting for the mid-start-bit recheck
// ST_DATA   | sampling data bits, LSB first
// ST_PARITY | sampling the even-parity bit
// ST_STOP   | sampling the stop bit, then judging the frame
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 signal,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF = half_bit(CLKS_PER_BIT);
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int CW   = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] BIT_RELOAD   = TW'(CLKS_PER_BIT - 1);
  // The detection cycle itself is the first half-bit cycle, so the recheck
  // lands HALF cycles after it; with HALF=0 START is skipped entirely.
  localparam logic [TW-1:0] START_RELOAD = (HALF == 0) ? BIT_RELOAD : TW'(HALF - 1);
  localparam logic [CW-1:0] LAST_BIT     = CW'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CW-1:0]        bit_cnt;
  logic                 par_acc;
  logic                 par_ok;

  logic                 tick;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 start_seen;
  logic                 stop_sample;
  logic                 frame_good;

  always_comb begin
    start_seen  = en && (state == ST_IDLE) && (signal == START_BIT);
    stop_sample = en && (state == ST_STOP) && tick;
    frame_good  = stop_sample && (signal == STOP_BIT) && par_ok;
    tmr_load    = 1'b0;
    tmr_val     = BIT_RELOAD;
    if (start_seen) begin
      tmr_load = 1'b1;
      tmr_val  = START_RELOAD;
    end else if (en && (state != ST_IDLE) && tick) begin
      tmr_load = 1'b1;
    end
  end

  uart_rx_ctrl_bit_timer #(
    .W(TW)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      par_ok     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (signal == START_BIT) begin
              shift_reg <= '0;
              bit_cnt   <= '0;
              par_acc   <= 1'b0;
              par_ok    <= 1'b1;
              busy      <= 1'b1;
              state     <= (HALF == 0) ? ST_DATA : ST_START;
            end
          end
          ST_START: begin
            if (tick) begin
              if (signal == START_BIT) begin
                state <= ST_DATA;
              end else begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (tick) begin
              // Right shift: the first bit received ends up in bit 0.
              shift_reg <= (shift_reg >> 1) | (DATA_BITS'(signal) << (DATA_BITS - 1));
              par_acc   <= par_acc ^ signal;
              bit_cnt   <= bit_cnt + CW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end
            end
          end
          ST_PARITY: begin
            if (tick) begin
              par_ok <= ~(par_acc ^ signal);
              state  <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (tick) begin
              if (signal != STOP_BIT) begin
                frame_err <= 1'b1;
              end else if (!par_ok) begin
                parity_err <= 1'b1;
              end
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // One-entry buffer: a completed frame may replace a word being accepted in
  // the same cycle; otherwise a full buffer drops it and flags overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (frame_good) begin
      if (!rx_valid || rx_ready) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
